// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } status_e;

  localparam int unsigned MIN_W = 8;
  localparam int unsigned SEC_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 8'd255;

  // Prescaler width: clog2(n), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Divides the clock down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
// tick is asserted combinationally on the edge the prescaler wraps, so the
// time counters advance on that same edge.
module stopwatch_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(TICKS_PER_SEC);
  localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = en & ~clr & (cnt_q == CntMax);

  // Prescaler: clear wins over enable, holds when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch.sv
// Minutes:seconds stopwatch with start/stop/reset controls and IDLE/RUNNING/PAUSED status.
// Optional build macro STOPWATCH_SATURATE_EN: stop at 255:59 and pause instead of wrapping.
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             reset,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       status
);

  status_e          state_q;
  logic [MIN_W-1:0] min_q;
  logic [SEC_W-1:0] sec_q;
  logic             tick;
  logic             run_en;
  logic             tick_clr;
  logic             resume_ok;

`ifdef STOPWATCH_SATURATE_EN
  logic at_max;
  assign at_max    = (min_q == MIN_MAX) && (sec_q == SEC_MAX);
  // Once saturated only reset can leave 255:59.
  assign resume_ok = start & ~stop & ~at_max;
`else
  assign resume_ok = start & ~stop;
`endif

  // A stop or reset on the same edge suppresses counting.
  assign run_en   = (state_q == ST_RUNNING) & ~stop & ~reset;
  assign tick_clr = reset | ((state_q == ST_IDLE) & start & ~stop);

  stopwatch_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .en   (run_en),
    .tick (tick)
  );

  // Control FSM: reset > stop > start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) state_q <= ST_RUNNING;
        end
        ST_RUNNING: begin
          if (stop) begin
            state_q <= ST_PAUSED;
`ifdef STOPWATCH_SATURATE_EN
          end else if (tick && at_max) begin
            state_q <= ST_PAUSED;
`endif
          end
        end
        ST_PAUSED: begin
          if (resume_ok) state_q <= ST_RUNNING;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Time counters: seconds roll over into minutes; minutes wrap or saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (reset) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (tick) begin
      if (sec_q == SEC_MAX) begin
`ifdef STOPWATCH_SATURATE_EN
        if (!at_max) begin
          sec_q <= '0;
          min_q <= min_q + 1'b1;
        end
`else
        sec_q <= '0;
        min_q <= min_q + 1'b1;
`endif
      end else begin
        sec_q <= sec_q + 1'b1;
      end
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign status  = state_q;

endmodule

// File: tb/tb_stopwatch.sv
// Scoreboard bench for stopwatch: two instances (10 and 1 cycles per second)
// share stimulus; a model based on elapsed running cycles predicts each edge.
module tb_stopwatch;

`ifdef STOPWATCH_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif
  localparam int TotalSecs = 256 * 60;

  logic clk;
  logic rst_n;
  logic start, stop, reset;
  logic [7:0] min0, min1;
  logic [5:0] sec0, sec1;
  logic [1:0] st0, st1;

  stopwatch #(.TICKS_PER_SEC(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .minutes(min0), .seconds(sec0), .status(st0)
  );

  stopwatch #(.TICKS_PER_SEC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .minutes(min1), .seconds(sec1), .status(st1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Model state: mode 0 idle / 1 running / 2 paused, cyc = running cycles counted.
  int m_mode[2];
  int m_cyc[2];
  int m_tps[2];

  logic [31:0] exp_q[$];

  function automatic logic [15:0] model_out(input int i);
    int secs;
    secs = (m_cyc[i] / m_tps[i]) % TotalSecs;
    return {m_mode[i][1:0], 8'(secs / 60), 6'(secs % 60)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_cyc[i]  = 0;
    end
  endtask

  task automatic model_step(input int i, input bit s, input bit p, input bit r);
    if (r) begin
      m_mode[i] = 0;
      m_cyc[i]  = 0;
    end else begin
      case (m_mode[i])
        0: if (s && !p) m_mode[i] = 1;
        1: begin
          if (p) begin
            m_mode[i] = 2;
          end else begin
            m_cyc[i]++;
            if (Sat && (m_cyc[i] / m_tps[i] >= TotalSecs)) begin
              m_cyc[i]--;
              m_mode[i] = 2;
            end
          end
        end
        default: begin
          if (s && !p && !(Sat && (m_cyc[i] / m_tps[i] == TotalSecs - 1))) m_mode[i] = 1;
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got st=%0d %0d:%0d, expected st=%0d %0d:%0d", name, cycle,
               got[15:14], got[13:6], got[5:0], want[15:14], want[13:6], want[5:0]);
    end
  endtask

  // Apply inputs for the coming edge and queue the predicted outputs.
  task automatic drive(input bit s, input bit p, input bit r);
    start = s;
    stop  = p;
    reset = r;
    for (int i = 0; i < 2; i++) model_step(i, s, p, r);
    exp_q.push_back({model_out(1), model_out(0)});
  endtask

  task automatic step(input bit s, input bit p, input bit r);
    @(negedge clk);
    drive(s, p, r);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every edge with a queued prediction is compared for both instances.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tps10", {st0, min0, sec0}, e[15:0]);
        check("tps1", {st1, min1, sec1}, e[31:16]);
      end
    end
  end

  initial begin
    m_tps[0] = 10;
    m_tps[1] = 1;
    model_reset();
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("por_tps10", {st0, min0, sec0}, 16'h0);
    check("por_tps1", {st1, min1, sec1}, 16'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    idle(5);

    // Count to 00:10, pause, resume mid-second.
    step(1'b1, 1'b0, 1'b0);
    idle(104);
    step(1'b0, 1'b1, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b0);
    idle(15);

    // Synchronous clear at 00:07.
    step(1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b0, 1'b0);
    idle(70);
    step(1'b0, 1'b0, 1'b1);
    idle(5);

    // Simultaneous start+stop while running, then in idle.
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(3);

    // Asynchronous reset between edges mid-count.
    step(1'b1, 1'b0, 1'b0);
    idle(23);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_tps10", {st0, min0, sec0}, 16'h0);
    check("async_tps1", {st1, min1, sec1}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0);

    // Random button traffic, including held levels.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 5), ($urandom_range(0, 199) == 0));
    end

    // Long run to the 255:59 boundary on the one-cycle-per-second instance.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(15400);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    idle(20);
    step(1'b0, 1'b0, 1'b1);
    idle(5);

    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
